wb_uart_debug_master: RTL and testbench
=======================================

Name: wb_uart_debug_master

Overview:
- Wishbone initiator driven by a byte stream. It decodes read/write command frames from the UART receive path, runs single Wishbone classic cycles, and returns response bytes to the UART transmit path.
- Connects as a second master, through an arbiter, on the same bus as the CPU pipeline. It gives host-side peek/poke access to RAM, UART and GPIO for bring-up.

Parameters:
- WB_TIMEOUT, 255, max cycles stb may stay high without ack before the cycle is abandoned (≥1)
- RX_TIMEOUT, 100000, max idle cycles between bytes of one frame before the frame is discarded (≥1)

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- rx_data  in  8  received byte, valid only when rx_valid=1
- rx_valid  in  1  one-cycle strobe per received byte; no backpressure
- tx_data  out  8  response byte
- tx_valid  out  1  response byte available
- tx_ready  in  1  transmitter accepts tx_data when tx_valid&tx_ready at a clock edge
- wb_cyc_o  out  1  Wishbone cycle
- wb_stb_o  out  1  Wishbone strobe
- wb_we_o  out  1  1=write, 0=read
- wb_adr_o  out  32  byte address
- wb_dat_o  out  32  write data
- wb_dat_i  in  32  read data
- wb_ack_i  in  1  slave acknowledge
- busy  out  1  high in every state except IDLE
- rx_drop  out  1  one-cycle pulse when an rx byte is discarded

Behaviour:
- Reset (async, rst_n=0): state=IDLE. All outputs are 0 immediately: cyc, stb, we, adr, dat_o, tx_valid, tx_data, busy, rx_drop. All counters are cleared. A reset during BUS drops cyc/stb at once and does not produce a response.
- All outputs are registered.
- Frame format, multi-byte fields MSB first:
  - Write frame: 0x57 'W', A3 A2 A1 A0, D3 D2 D1 D0.
  - Read frame: 0x52 'R', A3 A2 A1 A0.
- Responses:
  - Write: 0x4B 'K' on ack, 0x45 'E' on timeout.
  - Read: 0x44 'D', then R3 R2 R1 R0 on ack; 0x45 'E' on timeout.
  - Any other command byte in IDLE: response 0x3F '?'.
- States: IDLE, ADDR, DATA, BUS, RESP.
  - IDLE: rx_valid with 'W' or 'R' latches we=(byte==0x57) and goes to ADDR with byte index 0. Any other byte goes to RESP with 1 byte '?'.
  - ADDR: each rx_valid shifts the byte into the address shift register. After the 4th byte: write goes to DATA, read goes to BUS.
  - DATA: each rx_valid shifts into the data shift register. After the 4th byte, go to BUS.
  - BUS: the cycle after the last frame byte, cyc=stb=1 with adr, dat_o and we stable.
    - On a rising edge with wb_ack_i=1: capture wb_dat_i (read), deassert cyc/stb on the next cycle, go to RESP.
    - If WB_TIMEOUT edges elapse with stb=1 and no ack: deassert cyc/stb and go to RESP with 'E'.
    - An ack arriving on the same edge the timeout expires counts as success.
  - RESP: tx_valid=1 with tx_data stable until a handshake (tx_valid&tx_ready at an edge). The next byte is presented the cycle after the handshake, and tx_ready may be held high continuously. After the last byte, tx_valid=0 and go to IDLE.
- Inter-byte timeout: in ADDR/DATA, an idle counter resets on each rx_valid. When it reaches RX_TIMEOUT, return to IDLE silently with no response and no bus cycle.
- Bytes received in BUS or RESP are discarded and pulse rx_drop for 1 cycle. IDLE, ADDR and DATA never drop bytes.
- Output hold rules:
  - wb_adr_o and wb_dat_o hold their last values outside BUS.
  - wb_we_o is 0 outside BUS.
  - wb_dat_o shows 0 during reads.
- Only one bus cycle is outstanding at a time. Back-to-back frames are accepted from the cycle after RESP completes.

Test Plan:
- Write: rx 57 00 00 00 10 DE AD BE EF; slave acks 2 cycles after stb. Expected: one cycle with adr=0x00000010, dat_o=0xDEADBEEF, we=1, cyc=stb=1 for exactly 3 cycles; tx 4B.
- Read: rx 52 00 00 00 20; slave acks immediately with 0x12345678. Expected: we=0, adr=0x00000020; tx 44 12 34 56 78. Repeat with tx_ready low for 5 cycles before each handshake: tx_data stays stable and no byte is lost or repeated.
- Bus timeout: WB_TIMEOUT=8, rx 52 00 00 00 30, slave never acks. Expected: stb high exactly 8 cycles, then 0; tx 45. A following valid read then completes normally.
- Unknown command and frame abort: rx 0x41 → tx 3F, no bus cycle. RX_TIMEOUT=16, rx 57 00 00 then 20 idle cycles then 52 00 00 00 40 → the partial write is discarded and a read of 0x00000040 is performed.
- Drops: send a byte during BUS and another during RESP → rx_drop pulses twice and the response is unchanged.
- Reset mid-operation: assert rst_n=0 while stb=1 → cyc, stb and tx_valid go to 0 without waiting for a clock. After release, the next frame works correctly.

Source files
------------

// File: rtl/wb_uart_debug_master.sv
// Byte-stream driven Wishbone classic initiator: decodes 'W'/'R' frames from the UART
// receive path, runs one bus cycle and streams the response bytes back to the transmitter.
module wb_uart_debug_master #(
  parameter int unsigned WB_TIMEOUT = 255,
  parameter int unsigned RX_TIMEOUT = 100000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  output logic        wb_we_o,
  output logic [31:0] wb_adr_o,
  output logic [31:0] wb_dat_o,
  input  logic [31:0] wb_dat_i,
  input  logic        wb_ack_i,
  output logic        busy,
  output logic        rx_drop
);

  localparam int unsigned WB_CW = (WB_TIMEOUT > 1) ? $clog2(WB_TIMEOUT) : 1;
  localparam int unsigned RX_CW = (RX_TIMEOUT > 1) ? $clog2(RX_TIMEOUT) : 1;
  localparam logic [WB_CW-1:0] WB_LAST = WB_CW'(WB_TIMEOUT - 32'd1);
  localparam logic [WB_CW-1:0] WB_ONE  = WB_CW'(32'd1);
  localparam logic [WB_CW-1:0] WB_ZERO = WB_CW'(32'd0);
  localparam logic [RX_CW-1:0] RX_LAST = RX_CW'(RX_TIMEOUT - 32'd1);
  localparam logic [RX_CW-1:0] RX_ONE  = RX_CW'(32'd1);
  localparam logic [RX_CW-1:0] RX_ZERO = RX_CW'(32'd0);

  localparam logic [7:0] CMD_W = 8'h57;
  localparam logic [7:0] CMD_R = 8'h52;
  localparam logic [7:0] RSP_K = 8'h4B;
  localparam logic [7:0] RSP_E = 8'h45;
  localparam logic [7:0] RSP_D = 8'h44;
  localparam logic [7:0] RSP_Q = 8'h3F;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_ADDR = 3'd1,
    ST_DATA = 3'd2,
    ST_BUS  = 3'd3,
    ST_RESP = 3'd4
  } state_t;

  state_t           state_r, state_s;
  logic             cmd_we_r, cmd_we_s;
  logic [1:0]       byte_idx_r, byte_idx_s;
  logic [31:0]      adr_sh_r, adr_sh_s;
  logic [31:0]      dat_sh_r, dat_sh_s;
  logic [RX_CW-1:0] rx_idle_r, rx_idle_s;
  logic [WB_CW-1:0] wb_tmo_r, wb_tmo_s;
  logic [31:0]      resp_sh_r, resp_sh_s;
  logic [2:0]       resp_left_r, resp_left_s;
  logic             wb_cyc_r, wb_cyc_s;
  logic             wb_stb_r, wb_stb_s;
  logic             wb_we_r, wb_we_s;
  logic [31:0]      wb_adr_r, wb_adr_s;
  logic [31:0]      wb_dat_r, wb_dat_s;
  logic [7:0]       tx_data_r, tx_data_s;
  logic             tx_valid_r, tx_valid_s;
  logic             busy_r, busy_s;
  logic             rx_drop_r, rx_drop_s;

  // Next-state and next-output computation; every output is the registered copy of these.
  always_comb begin
    state_s     = state_r;
    cmd_we_s    = cmd_we_r;
    byte_idx_s  = byte_idx_r;
    adr_sh_s    = adr_sh_r;
    dat_sh_s    = dat_sh_r;
    rx_idle_s   = rx_idle_r;
    wb_tmo_s    = wb_tmo_r;
    resp_sh_s   = resp_sh_r;
    resp_left_s = resp_left_r;
    wb_cyc_s    = wb_cyc_r;
    wb_stb_s    = wb_stb_r;
    wb_we_s     = wb_we_r;
    wb_adr_s    = wb_adr_r;
    wb_dat_s    = wb_dat_r;
    tx_data_s   = tx_data_r;
    tx_valid_s  = tx_valid_r;
    rx_drop_s   = 1'b0;

    case (state_r)
      ST_IDLE: begin
        if (rx_valid && (rx_data == CMD_W || rx_data == CMD_R)) begin
          cmd_we_s   = (rx_data == CMD_W);
          byte_idx_s = 2'd0;
          rx_idle_s  = RX_ZERO;
          state_s    = ST_ADDR;
        end else if (rx_valid) begin
          tx_data_s   = RSP_Q;
          tx_valid_s  = 1'b1;
          resp_left_s = 3'd0;
          state_s     = ST_RESP;
        end else begin
          state_s = ST_IDLE;
        end
      end

      ST_ADDR, ST_DATA: begin
        if (rx_valid) begin
          rx_idle_s  = RX_ZERO;
          byte_idx_s = byte_idx_r + 2'd1;
          if (state_r == ST_ADDR) begin
            adr_sh_s = {adr_sh_r[23:0], rx_data};
          end else begin
            dat_sh_s = {dat_sh_r[23:0], rx_data};
          end
          if (byte_idx_r != 2'd3) begin
            state_s = state_r;
          end else if (state_r == ST_ADDR && cmd_we_r) begin
            state_s = ST_DATA;
          end else begin
            // Frame complete: launch the bus cycle on the very next clock.
            state_s  = ST_BUS;
            wb_cyc_s = 1'b1;
            wb_stb_s = 1'b1;
            wb_we_s  = cmd_we_r;
            wb_adr_s = adr_sh_s;
            wb_dat_s = cmd_we_r ? dat_sh_s : 32'h0000_0000;
            wb_tmo_s = WB_ZERO;
          end
        end else if (rx_idle_r == RX_LAST) begin
          state_s = ST_IDLE;
        end else begin
          rx_idle_s = rx_idle_r + RX_ONE;
        end
      end

      ST_BUS: begin
        rx_drop_s = rx_valid;
        if (wb_ack_i) begin
          wb_cyc_s   = 1'b0;
          wb_stb_s   = 1'b0;
          wb_we_s    = 1'b0;
          tx_valid_s = 1'b1;
          state_s    = ST_RESP;
          if (cmd_we_r) begin
            tx_data_s   = RSP_K;
            resp_left_s = 3'd0;
          end else begin
            tx_data_s   = RSP_D;
            resp_sh_s   = wb_dat_i;
            resp_left_s = 3'd4;
          end
        end else if (wb_tmo_r == WB_LAST) begin
          wb_cyc_s    = 1'b0;
          wb_stb_s    = 1'b0;
          wb_we_s     = 1'b0;
          tx_data_s   = RSP_E;
          tx_valid_s  = 1'b1;
          resp_left_s = 3'd0;
          state_s     = ST_RESP;
        end else begin
          wb_tmo_s = wb_tmo_r + WB_ONE;
        end
      end

      ST_RESP: begin
        rx_drop_s = rx_valid;
        if (tx_valid_r && tx_ready && resp_left_r == 3'd0) begin
          tx_valid_s = 1'b0;
          state_s    = ST_IDLE;
        end else if (tx_valid_r && tx_ready) begin
          tx_data_s   = resp_sh_r[31:24];
          resp_sh_s   = {resp_sh_r[23:0], 8'h00};
          resp_left_s = resp_left_r - 3'd1;
        end else begin
          state_s = ST_RESP;
        end
      end

      default: begin
        state_s    = ST_IDLE;
        wb_cyc_s   = 1'b0;
        wb_stb_s   = 1'b0;
        wb_we_s    = 1'b0;
        tx_valid_s = 1'b0;
      end
    endcase

    busy_s = (state_s != ST_IDLE);
  end

  // State and output registers; reset clears everything without waiting for a clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      cmd_we_r    <= 1'b0;
      byte_idx_r  <= 2'd0;
      adr_sh_r    <= 32'h0000_0000;
      dat_sh_r    <= 32'h0000_0000;
      rx_idle_r   <= RX_ZERO;
      wb_tmo_r    <= WB_ZERO;
      resp_sh_r   <= 32'h0000_0000;
      resp_left_r <= 3'd0;
      wb_cyc_r    <= 1'b0;
      wb_stb_r    <= 1'b0;
      wb_we_r     <= 1'b0;
      wb_adr_r    <= 32'h0000_0000;
      wb_dat_r    <= 32'h0000_0000;
      tx_data_r   <= 8'h00;
      tx_valid_r  <= 1'b0;
      busy_r      <= 1'b0;
      rx_drop_r   <= 1'b0;
    end else begin
      state_r     <= state_s;
      cmd_we_r    <= cmd_we_s;
      byte_idx_r  <= byte_idx_s;
      adr_sh_r    <= adr_sh_s;
      dat_sh_r    <= dat_sh_s;
      rx_idle_r   <= rx_idle_s;
      wb_tmo_r    <= wb_tmo_s;
      resp_sh_r   <= resp_sh_s;
      resp_left_r <= resp_left_s;
      wb_cyc_r    <= wb_cyc_s;
      wb_stb_r    <= wb_stb_s;
      wb_we_r     <= wb_we_s;
      wb_adr_r    <= wb_adr_s;
      wb_dat_r    <= wb_dat_s;
      tx_data_r   <= tx_data_s;
      tx_valid_r  <= tx_valid_s;
      busy_r      <= busy_s;
      rx_drop_r   <= rx_drop_s;
    end
  end

  assign wb_cyc_o = wb_cyc_r;
  assign wb_stb_o = wb_stb_r;
  assign wb_we_o  = wb_we_r;
  assign wb_adr_o = wb_adr_r;
  assign wb_dat_o = wb_dat_r;
  assign tx_data  = tx_data_r;
  assign tx_valid = tx_valid_r;
  assign busy     = busy_r;
  assign rx_drop  = rx_drop_r;

endmodule

// File: tb/tb_wb_uart_debug_master.sv
// Scoreboard bench for wb_uart_debug_master: stimulus pushes expected bus cycles and tx
// bytes into queues, a negedge monitor pops and compares as the DUT presents them.
module tb_wb_uart_debug_master;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b0;
  logic        wb_cyc_o, wb_stb_o, wb_we_o;
  logic [31:0] wb_adr_o, wb_dat_o;
  logic [31:0] wb_dat_i = 32'hBAD0_BAD0;
  logic        wb_ack_i = 1'b0;
  logic        busy, rx_drop;

  wb_uart_debug_master #(.WB_TIMEOUT(8), .RX_TIMEOUT(16)) dut (
    .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o),
    .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i),
    .wb_ack_i(wb_ack_i), .busy(busy), .rx_drop(rx_drop)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] adr;
    logic [31:0] dat;
    logic        we;
    logic [7:0]  len;   // expected stb cycles, 0 = cycle aborted by reset
  } bus_t;

  bus_t        bus_q[$];
  logic [7:0]  tx_q[$];
  int          n_cmp = 0;
  int          n_err = 0;
  int          ack_delay = 0;
  int          ack_cnt = 0;
  logic [31:0] slave_rdata = 32'h0;
  logic        slow_mode = 1'b0;
  int          wcnt = 0;
  int          drop_cnt = 0;
  int          stb_len = 0;
  bus_t        cur;
  logic        prev_valid = 1'b0;
  logic        prev_ready = 1'b0;
  logic [7:0]  prev_data = 8'h00;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name, input string what);
    n_cmp++;
    n_err++;
    $display("FAIL %s: %s", name, what);
  endtask

  function automatic bus_t mk(input logic [31:0] adr, input logic [31:0] dat,
                              input logic we, input logic [7:0] len);
    bus_t b;
    b.adr = adr; b.dat = dat; b.we = we; b.len = len;
    return b;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic send32(input logic [31:0] v);
    send_byte(v[31:24]);
    send_byte(v[23:16]);
    send_byte(v[15:8]);
    send_byte(v[7:0]);
  endtask

  task automatic wait_idle(input string name, input int budget);
    bit done = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (tx_q.size() == 0 && bus_q.size() == 0 && !busy) begin
        done = 1'b1;
        break;
      end
      tick();
    end
    if (!done) fail(name, $sformatf("still busy with %0d tx bytes pending, required idle", tx_q.size()));
  endtask

  // Wishbone slave: ack after ack_delay full stb cycles.
  always @(negedge clk) begin
    if (wb_stb_o && rst_n) begin
      if (ack_cnt == ack_delay) begin
        wb_ack_i = 1'b1;
        wb_dat_i = slave_rdata;
      end else begin
        wb_ack_i = 1'b0;
        wb_dat_i = 32'hBAD0_BAD0;
      end
      ack_cnt++;
    end else begin
      wb_ack_i = 1'b0;
      wb_dat_i = 32'hBAD0_BAD0;
      ack_cnt  = 0;
    end
  end

  // Transmit sink: always ready, or stalls 5+ cycles before each byte in slow mode.
  always @(posedge clk) begin
    #1;
    if (!slow_mode) begin
      tx_ready = 1'b1;
      wcnt = 0;
    end else if (tx_ready) begin
      tx_ready = 1'b0;
      wcnt = 0;
    end else if (tx_valid) begin
      if (wcnt == 4) tx_ready = 1'b1;
      else wcnt++;
    end
  end

  // Monitor: values at negedge are what the next rising edge will see.
  always @(negedge clk) begin
    if (!rst_n) begin
      if (stb_len > 0 && bus_q.size() > 0) cur = bus_q.pop_front();
      stb_len    = 0;
      prev_valid = 1'b0;
      prev_ready = 1'b0;
    end else begin
      if (wb_cyc_o || wb_stb_o) chk("cyc_eq_stb", 32'(wb_cyc_o), 32'(wb_stb_o));
      if (wb_stb_o) begin
        if (stb_len == 0) begin
          if (bus_q.size() == 0) begin
            fail("bus_extra", $sformatf("bus cycle at 0x%0h, required none", wb_adr_o));
          end else begin
            cur = bus_q[0];
            chk("bus_adr", wb_adr_o, cur.adr);
            chk("bus_we", 32'(wb_we_o), 32'(cur.we));
            chk("bus_dat", wb_dat_o, cur.dat);
          end
        end else begin
          chk("bus_adr_hold", wb_adr_o, cur.adr);
        end
        stb_len++;
      end else if (stb_len > 0) begin
        if (bus_q.size() > 0) begin
          cur = bus_q.pop_front();
          if (cur.len != 8'd0) chk("stb_len", 32'(stb_len), 32'(cur.len));
        end
        chk("we_idle", 32'(wb_we_o), 32'd0);
        stb_len = 0;
      end

      if (tx_valid && prev_valid && !prev_ready) chk("tx_hold", 32'(tx_data), 32'(prev_data));
      if (tx_valid && tx_ready) begin
        if (tx_q.size() == 0) fail("tx_extra", $sformatf("byte 0x%0h sent, required none", tx_data));
        else chk("tx_byte", 32'(tx_data), 32'(tx_q.pop_front()));
      end
      prev_valid = tx_valid;
      prev_ready = tx_ready;
      prev_data  = tx_data;
      if (rx_drop) drop_cnt++;
    end
  end

  initial begin
    int drop0;
    rst_n    = 1'b0;
    rx_data  = 8'h00;
    rx_valid = 1'b0;
    #1;
    chk("rst_cyc", 32'(wb_cyc_o), 32'd0);
    chk("rst_stb", 32'(wb_stb_o), 32'd0);
    chk("rst_we", 32'(wb_we_o), 32'd0);
    chk("rst_adr", wb_adr_o, 32'd0);
    chk("rst_dat", wb_dat_o, 32'd0);
    chk("rst_tx_valid", 32'(tx_valid), 32'd0);
    chk("rst_tx_data", 32'(tx_data), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_rx_drop", 32'(rx_drop), 32'd0);
    #20 rst_n = 1'b1;
    tick();

    // Write, ack after 2 wait cycles -> stb for 3 cycles, reply 'K'
    ack_delay = 2;
    bus_q.push_back(mk(32'h0000_0010, 32'hDEAD_BEEF, 1'b1, 8'd3));
    tx_q.push_back(8'h4B);
    send_byte(8'h57); send32(32'h0000_0010); send32(32'hDEAD_BEEF);
    chk("busy_in_bus", 32'(busy), 32'd1);
    wait_idle("write_done", 100);

    // Read, immediate ack
    ack_delay = 0; slave_rdata = 32'h1234_5678;
    bus_q.push_back(mk(32'h0000_0020, 32'h0, 1'b0, 8'd1));
    tx_q.push_back(8'h44); tx_q.push_back(8'h12); tx_q.push_back(8'h34);
    tx_q.push_back(8'h56); tx_q.push_back(8'h78);
    send_byte(8'h52); send32(32'h0000_0020);
    wait_idle("read_done", 100);

    // Same read with the transmitter stalling before every byte
    slow_mode = 1'b1; slave_rdata = 32'h9ABC_DEF0;
    bus_q.push_back(mk(32'h0000_0020, 32'h0, 1'b0, 8'd1));
    tx_q.push_back(8'h44); tx_q.push_back(8'h9A); tx_q.push_back(8'hBC);
    tx_q.push_back(8'hDE); tx_q.push_back(8'hF0);
    send_byte(8'h52); send32(32'h0000_0020);
    wait_idle("read_stall_done", 200);
    slow_mode = 1'b0;
    tick();

    // No ack: stb for exactly 8 cycles, reply 'E'; then a normal read
    ack_delay = 1000;
    bus_q.push_back(mk(32'h0000_0030, 32'h0, 1'b0, 8'd8));
    tx_q.push_back(8'h45);
    send_byte(8'h52); send32(32'h0000_0030);
    wait_idle("timeout_done", 100);
    ack_delay = 0; slave_rdata = 32'h0F1E_2D3C;
    bus_q.push_back(mk(32'h0000_0034, 32'h0, 1'b0, 8'd1));
    tx_q.push_back(8'h44); tx_q.push_back(8'h0F); tx_q.push_back(8'h1E);
    tx_q.push_back(8'h2D); tx_q.push_back(8'h3C);
    send_byte(8'h52); send32(32'h0000_0034);
    wait_idle("post_timeout_read", 100);

    // Unknown command
    tx_q.push_back(8'h3F);
    send_byte(8'h41);
    wait_idle("unknown_done", 50);

    // Partial write abandoned after 16 idle cycles, then a read
    send_byte(8'h57); send_byte(8'h00); send_byte(8'h00);
    repeat (10) tick();
    chk("partial_busy", 32'(busy), 32'd1);
    repeat (10) tick();
    chk("abort_idle", 32'(busy), 32'd0);
    ack_delay = 1; slave_rdata = 32'h0BAD_CAFE;
    bus_q.push_back(mk(32'h0000_0040, 32'h0, 1'b0, 8'd2));
    tx_q.push_back(8'h44); tx_q.push_back(8'h0B); tx_q.push_back(8'hAD);
    tx_q.push_back(8'hCA); tx_q.push_back(8'hFE);
    send_byte(8'h52); send32(32'h0000_0040);
    wait_idle("abort_read_done", 100);

    // Bytes during BUS and RESP are dropped
    ack_delay = 3; slow_mode = 1'b1; slave_rdata = 32'h1357_9BDF; drop0 = drop_cnt;
    bus_q.push_back(mk(32'h0000_0044, 32'h0, 1'b0, 8'd4));
    tx_q.push_back(8'h44); tx_q.push_back(8'h13); tx_q.push_back(8'h57);
    tx_q.push_back(8'h9B); tx_q.push_back(8'hDF);
    send_byte(8'h52); send32(32'h0000_0044);
    send_byte(8'h57);
    for (int i = 0; i < 30; i++) begin
      if (tx_valid) break;
      tick();
    end
    if (!tx_valid) fail("resp_wait", "tx_valid never rose, required response");
    send_byte(8'h52);
    wait_idle("drop_done", 200);
    slow_mode = 1'b0;
    tick();
    chk("rx_drop_count", 32'(drop_cnt - drop0), 32'd2);

    // Reset while stb is high
    ack_delay = 1000;
    bus_q.push_back(mk(32'h0000_0050, 32'h0, 1'b0, 8'd0));
    send_byte(8'h52); send32(32'h0000_0050);
    tick();
    chk("stb_before_rst", 32'(wb_stb_o), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_async_cyc", 32'(wb_cyc_o), 32'd0);
    chk("rst_async_stb", 32'(wb_stb_o), 32'd0);
    chk("rst_async_tx_valid", 32'(tx_valid), 32'd0);
    chk("rst_async_busy", 32'(busy), 32'd0);
    tick(); tick();
    rst_n = 1'b1;
    tick();
    ack_delay = 0;
    bus_q.push_back(mk(32'h0000_0060, 32'h1122_3344, 1'b1, 8'd1));
    tx_q.push_back(8'h4B);
    send_byte(8'h57); send32(32'h0000_0060); send32(32'h1122_3344);
    wait_idle("post_reset_write", 100);

    repeat (3) tick();
    chk("tx_q_empty", 32'(tx_q.size()), 32'd0);
    chk("bus_q_empty", 32'(bus_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
